// File: rtl/dm_sim_monitor.sv
// Snoops the DM1 SRAM request port: counts cycles, logs writes to the test-result
// region into a FIFO drained by the bench, and flags end-of-program or timeout.
module dm_sim_monitor #(
  parameter int              ADDR_W       = 14,
  parameter logic [13:0]     SIM_END_ADDR = 14'h3fff,
  parameter logic [31:0]     END_CODE     = 32'hffff_ffff,
  parameter logic [13:0]     LOG_LO       = 14'h2000,
  parameter logic [13:0]     LOG_HI       = 14'h3ffe,
  parameter int              LOG_DEPTH    = 8,
  parameter int              MAX_CYCLE    = 200000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dm_ceb,
  input  logic              dm_web,
  input  logic [31:0]       dm_bweb,
  input  logic [ADDR_W-1:0] dm_a,
  input  logic [31:0]       dm_d,
  output logic              log_valid,
  input  logic              log_ready,
  output logic [ADDR_W-1:0] log_addr,
  output logic [31:0]       log_data,
  output logic [31:0]       log_mask,
  output logic              log_ovf,
  output logic [15:0]       drop_cnt,
  output logic [63:0]       total_cycle,
  output logic              sim_done,
  output logic              sim_timeout
);

  localparam int PTR_W   = $clog2(LOG_DEPTH);
  localparam int ENTRY_W = ADDR_W + 64;

  typedef enum logic [1:0] {RUN, DRAIN, DONE, TIMEOUT} state_t;

  state_t state, state_nxt;

  logic [ENTRY_W-1:0] mem [LOG_DEPTH];
  logic [PTR_W-1:0]   rd_ptr, wr_ptr;
  logic [PTR_W:0]     count;

  logic        wr_ev, end_det, in_win;
  logic        push_req, push, pop, full, drop;
  logic [63:0] cycle_nxt;

  assign wr_ev   = !dm_ceb && !dm_web;
  assign end_det = wr_ev && (dm_a == ADDR_W'(SIM_END_ADDR)) && (dm_bweb == 32'h0)
                   && (dm_d == END_CODE);
  assign in_win  = (dm_a >= ADDR_W'(LOG_LO)) && (dm_a <= ADDR_W'(LOG_HI));

  assign full      = (count == (PTR_W+1)'(LOG_DEPTH));
  assign log_valid = (count != '0);
  assign pop       = log_valid && log_ready;
  assign push_req  = (state == RUN) && wr_ev && in_win;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign push      = push_req && (!full || pop);
  assign drop      = push_req && full && !pop;
  assign cycle_nxt = total_cycle + 64'd1;

  assign {log_addr, log_data, log_mask} = mem[rd_ptr];
  assign sim_done    = (state == DONE);
  assign sim_timeout = (state == TIMEOUT);

  always_comb begin
    state_nxt = state;
    case (state)
      RUN: begin
        if (end_det)
          state_nxt = DRAIN;
        else if (cycle_nxt == 64'(MAX_CYCLE))
          state_nxt = TIMEOUT;
      end
      DRAIN: begin
        if ((count == '0) || ((count == (PTR_W+1)'(1)) && pop))
          state_nxt = DONE;
      end
      default: state_nxt = state;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      total_cycle <= 64'd0;
    end else begin
      state <= state_nxt;
      if (state == RUN)
        total_cycle <= cycle_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LOG_DEPTH; i++)
        mem[i] <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      log_ovf  <= 1'b0;
      drop_cnt <= 16'h0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {dm_a, dm_d, ~dm_bweb};
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)
        count <= count + (PTR_W+1)'(1);
      else if (pop && !push)
        count <= count - (PTR_W+1)'(1);
      if (drop) begin
        log_ovf <= 1'b1;
        if (drop_cnt != 16'hffff)
          drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_dm_sim_monitor.sv
// Directed bench for dm_sim_monitor: end detect, log ordering, overflow,
// drain gating, non-end writes, timeout and asynchronous reset.
module tb_dm_sim_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        dm_ceb, dm_web;
  logic [31:0] dm_bweb, dm_d;
  logic [13:0] dm_a;
  logic        log_valid, log_ready;
  logic [13:0] log_addr;
  logic [31:0] log_data, log_mask;
  logic        log_ovf;
  logic [15:0] drop_cnt;
  logic [63:0] total_cycle;
  logic        sim_done, sim_timeout;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  dm_sim_monitor #(.MAX_CYCLE(50)) dut (
    .clk(clk), .rst(rst),
    .dm_ceb(dm_ceb), .dm_web(dm_web), .dm_bweb(dm_bweb), .dm_a(dm_a), .dm_d(dm_d),
    .log_valid(log_valid), .log_ready(log_ready),
    .log_addr(log_addr), .log_data(log_data), .log_mask(log_mask),
    .log_ovf(log_ovf), .drop_cnt(drop_cnt), .total_cycle(total_cycle),
    .sim_done(sim_done), .sim_timeout(sim_timeout)
  );

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_idle();
    dm_ceb  = 1'b1;
    dm_web  = 1'b1;
    dm_bweb = 32'hffff_ffff;
    dm_a    = 14'h0;
    dm_d    = 32'h0;
  endtask

  task automatic apply_stimulus(input logic [13:0] a, input logic [31:0] d, input logic [31:0] bweb);
    dm_ceb  = 1'b0;
    dm_web  = 1'b0;
    dm_a    = a;
    dm_d    = d;
    dm_bweb = bweb;
    tick();
    set_idle();
  endtask

  task automatic start_test();
    @(negedge clk);
    rst = 1'b1;
    set_idle();
    log_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    set_idle();
    log_ready = 1'b0;
    #1;
    check_output("rst_total_cycle", total_cycle, 64'd0);
    check_output("rst_log_valid", 64'(log_valid), 64'd0);
    check_output("rst_sim_done", 64'(sim_done), 64'd0);
    check_output("rst_sim_timeout", 64'(sim_timeout), 64'd0);

    // End only: 9 idle edges then the end marker on the 10th.
    start_test();
    for (int i = 0; i < 9; i++) begin
      tick();
      check_output("end_idle_log_valid", 64'(log_valid), 64'd0);
    end
    apply_stimulus(14'h3fff, 32'hffff_ffff, 32'h0);
    check_output("end_cycle_at_edge", total_cycle, 64'd10);
    check_output("end_done_not_yet", 64'(sim_done), 64'd0);
    tick();
    check_output("end_done", 64'(sim_done), 64'd1);
    check_output("end_cycle_frozen", total_cycle, 64'd10);
    check_output("end_log_valid", 64'(log_valid), 64'd0);

    // Log order with a stalled consumer, then drain.
    start_test();
    apply_stimulus(14'h2000, 32'h11, 32'h0);
    apply_stimulus(14'h2001, 32'h22, 32'h0);
    apply_stimulus(14'h2002, 32'h33, 32'h0);
    tick();
    check_output("order_stall_addr", 64'(log_addr), 64'h2000);
    check_output("order_stall_valid", 64'(log_valid), 64'd1);
    log_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check_output("order_addr", 64'(log_addr), 64'h2000 + 64'(i));
      check_output("order_data", 64'(log_data), 64'h11 * 64'(i + 1));
      check_output("order_mask", 64'(log_mask), 64'hffff_ffff);
      tick();
    end
    check_output("order_empty", 64'(log_valid), 64'd0);
    check_output("order_drop_cnt", 64'(drop_cnt), 64'd0);
    check_output("order_ovf", 64'(log_ovf), 64'd0);

    // Overflow: 10 writes into an 8-deep FIFO, then push+pop while full.
    start_test();
    for (int i = 0; i < 10; i++)
      apply_stimulus(14'h2000 + 14'(i), 32'h100 + 32'(i), 32'h0);
    check_output("ovf_flag", 64'(log_ovf), 64'd1);
    check_output("ovf_drop_cnt", 64'(drop_cnt), 64'd2);
    check_output("ovf_head", 64'(log_addr), 64'h2000);
    log_ready = 1'b1;
    apply_stimulus(14'h2100, 32'haa, 32'hffff_0000);
    check_output("ovf_pushpop_drop_cnt", 64'(drop_cnt), 64'd2);
    for (int i = 1; i < 8; i++) begin
      check_output("ovf_drain_addr", 64'(log_addr), 64'h2000 + 64'(i));
      check_output("ovf_drain_data", 64'(log_data), 64'h100 + 64'(i));
      tick();
    end
    check_output("ovf_last_addr", 64'(log_addr), 64'h2100);
    check_output("ovf_last_data", 64'(log_data), 64'haa);
    check_output("ovf_last_mask", 64'(log_mask), 64'h0000_ffff);
    tick();
    check_output("ovf_empty", 64'(log_valid), 64'd0);

    // Drain gating: sim_done waits for the log to empty.
    start_test();
    apply_stimulus(14'h2010, 32'ha, 32'h0);
    apply_stimulus(14'h2011, 32'hb, 32'h0);
    apply_stimulus(14'h2012, 32'hc, 32'h0);
    apply_stimulus(14'h3fff, 32'hffff_ffff, 32'h0);
    check_output("drain_cycle", total_cycle, 64'd4);
    apply_stimulus(14'h2013, 32'hd, 32'h0);
    check_output("drain_wait_done", 64'(sim_done), 64'd0);
    log_ready = 1'b1;
    tick();
    check_output("drain_pop1_done", 64'(sim_done), 64'd0);
    tick();
    check_output("drain_pop2_done", 64'(sim_done), 64'd0);
    check_output("drain_pop2_addr", 64'(log_addr), 64'h2012);
    tick();
    check_output("drain_pop3_done", 64'(sim_done), 64'd1);
    check_output("drain_empty", 64'(log_valid), 64'd0);
    check_output("drain_cycle_frozen", total_cycle, 64'd4);

    // Non-end writes at the marker address and a read in the log window.
    start_test();
    apply_stimulus(14'h3fff, 32'hffff_ffff, 32'h0000_ffff);
    apply_stimulus(14'h3fff, 32'h1, 32'h0);
    dm_ceb = 1'b0; dm_web = 1'b1; dm_a = 14'h2000; dm_d = 32'h55; dm_bweb = 32'h0;
    tick();
    set_idle();
    check_output("nonend_log_valid", 64'(log_valid), 64'd0);
    tick();
    check_output("nonend_done", 64'(sim_done), 64'd0);
    check_output("nonend_cycle_runs", total_cycle, 64'd4);

    // Timeout at MAX_CYCLE=50; later end marker and log writes ignored.
    start_test();
    for (int i = 0; i < 49; i++) tick();
    check_output("to_before_cycle", total_cycle, 64'd49);
    check_output("to_before_flag", 64'(sim_timeout), 64'd0);
    tick();
    check_output("to_flag", 64'(sim_timeout), 64'd1);
    check_output("to_cycle", total_cycle, 64'd50);
    apply_stimulus(14'h3fff, 32'hffff_ffff, 32'h0);
    apply_stimulus(14'h2000, 32'h77, 32'h0);
    check_output("to_end_ignored", 64'(sim_done), 64'd0);
    check_output("to_cycle_frozen", total_cycle, 64'd50);
    check_output("to_no_log", 64'(log_valid), 64'd0);
    check_output("to_flag_held", 64'(sim_timeout), 64'd1);

    // Asynchronous reset in the middle of DRAIN.
    start_test();
    apply_stimulus(14'h2020, 32'h99, 32'h0);
    apply_stimulus(14'h2021, 32'h98, 32'h0);
    apply_stimulus(14'h3fff, 32'hffff_ffff, 32'h0);
    check_output("mid_valid_before", 64'(log_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    check_output("mid_log_valid", 64'(log_valid), 64'd0);
    check_output("mid_total_cycle", total_cycle, 64'd0);
    check_output("mid_log_addr", 64'(log_addr), 64'd0);
    check_output("mid_log_data", 64'(log_data), 64'd0);
    check_output("mid_sim_done", 64'(sim_done), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check_output("mid_restart_cycle", total_cycle, 64'd1);
    check_output("mid_restart_valid", 64'(log_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
